mux_select_sequencer: RTL and testbench

Generates the 2-bit channel select for the downstream 4-to-1 multiplexer, replacing the hand-set SW[9:8] select switches. It steps through channels 0→1→2→3→0 either automatically at a fixed divided rate or once per debounced push-button press. It sits between the board inputs (clock, KEY, SW) and the mux select pins; the mux data path is untouched.

---
 rtl/mux_seq_pkg.sv | 28 ++
 rtl/key_debouncer.sv | 113 +++++++++++
 rtl/mux_select_sequencer.sv | 86 ++++++++
 tb/tb_mux_select_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_seq_pkg.sv
// Shared types and constants for the mux select sequencer.
// The debouncer state encoding is shared with the top so the state can be
// observed from outside the block.
package mux_seq_pkg;

    // Width of the mux channel select and number of channels it addresses.
    localparam int SEL_W  = 2;
    localparam int NUM_CH = 4;

    // Push-button debouncer states.
    //   IDLE      : button accepted as released, waiting for a high level
    //   PRESS_CHK : high level seen, counting stable-high cycles
    //   HELD      : press accepted, waiting for a low level
    //   REL_CHK   : low level seen, counting stable-low cycles
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } db_state_e;

    // Next channel in the 0->1->2->3->0 rotation. NUM_CH equals 2**SEL_W,
    // so the natural binary wrap of the adder gives the modulo.
    function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] cur);
        next_sel = cur + {{(SEL_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Push-button conditioner: two-flop synchronizer followed by a four-state
// debouncer. Emits a single-cycle registered pulse for every press that stays
// high for DEBOUNCE consecutive synchronized samples; releases must likewise
// stay low for DEBOUNCE samples before another press can be accepted.
module key_debouncer
    import mux_seq_pkg::*;
#(
    parameter int DEBOUNCE = 500_000
) (
    input  logic      clock_i,
    input  logic      reset_i,
    input  logic      step_i,
    output logic      press_o,
    output db_state_e state_o
);

    // Counter is wide enough to hold DEBOUNCE-1, the largest value it reaches.
    localparam int CW = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          sync1_q;
    logic          sync2_q;
    db_state_e     state_q;
    db_state_e     state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          press_q;
    logic          press_d;

    // Bring the asynchronous button level into the clock domain; only sync2 is used.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= step_i;
            sync2_q <= sync2_next(sync1_q);
        end
    end

    // Identity helper keeps the second stage visibly distinct from the first.
    function automatic logic sync2_next(input logic lvl);
        sync2_next = lvl;
    endfunction

    // Debounce decision: count consecutive stable samples in the check states.
    // The sample that moves IDLE->PRESS_CHK or HELD->REL_CHK counts as the first.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    state_d = PRESS_CHK;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_CHK: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (!sync2_q) begin
                    state_d = REL_CHK;
                    cnt_d   = CNT_ONE;
                end
            end
            REL_CHK: begin
                if (sync2_q) begin
                    // Bounce during release: the press is still in progress.
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Debouncer state, counter and registered press pulse.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;
    assign state_o = state_q;

endmodule

// File: rtl/mux_select_sequencer.sv
// Channel select generator for a downstream 4-to-1 multiplexer.
// Steps sel through 0->1->2->3->0 either automatically every DIV_COUNT cycles
// (auto_mode=1) or once per debounced button press (auto_mode=0). enable=0
// freezes sel; presses arriving while frozen or in auto mode are dropped.
// sel and sel_changed are registered; no input reaches them combinationally.
// dbg_state reflects the debouncer state for observation only.
module mux_select_sequencer
    import mux_seq_pkg::*;
#(
    parameter int DIV_COUNT = 50_000_000,
    parameter int DEBOUNCE  = 500_000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             auto_mode,
    input  logic             step_in,
    output logic [SEL_W-1:0] sel,
    output logic             sel_changed,
    output logic [1:0]       dbg_state
);

    // Divider counts DIV_COUNT-1 down to 0, so it needs $clog2(DIV_COUNT) bits.
    localparam int DW = (DIV_COUNT > 2) ? $clog2(DIV_COUNT) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV_COUNT - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);

    logic             press;
    db_state_e        db_state;

    logic             run;
    logic             tick;
    logic             advance;
    logic [DW-1:0]    div_cnt_q;
    logic [DW-1:0]    div_cnt_d;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_d;
    logic             changed_q;
    logic             changed_d;

    key_debouncer #(
        .DEBOUNCE (DEBOUNCE)
    ) u_key_debouncer (
        .clock_i (clock),
        .reset_i (reset),
        .step_i  (step_in),
        .press_o (press),
        .state_o (db_state)
    );

    // Rate divider: free-runs only while enabled in auto mode; otherwise it is
    // held at full count so every re-entry starts a fresh period.
    always_comb begin
        run       = enable & auto_mode;
        tick      = run & (div_cnt_q == '0);
        div_cnt_d = DIV_LAST;
        if (run && (div_cnt_q != '0)) begin
            div_cnt_d = div_cnt_q - DIV_ONE;
        end
    end

    // Advance decision: divider tick in auto mode, press in manual mode.
    always_comb begin
        advance   = enable & ((auto_mode & tick) | (~auto_mode & press));
        sel_d     = advance ? next_sel(sel_q) : sel_q;
        changed_d = advance;
    end

    // Divider, select and change-pulse registers; reset wins over any event.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt_q <= DIV_LAST;
            sel_q     <= '0;
            changed_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            sel_q     <= sel_d;
            changed_q <= changed_d;
        end
    end

    assign sel         = sel_q;
    assign sel_changed = changed_q;
    assign dbg_state   = db_state;

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Bench for mux_select_sequencer with DIV_COUNT=4, DEBOUNCE=3.
// A run-length reference model predicts sel, sel_changed and the debouncer
// state every cycle; directed phases add hand-computed literal expectations.
module tb_mux_select_sequencer;
    import mux_seq_pkg::*;

    localparam int DIV = 4;
    localparam int DB  = 3;

    // ---------------- clock / reset / DUT ----------------
    logic       clock     = 1'b0;
    logic       reset     = 1'b1;
    logic       enable    = 1'b0;
    logic       auto_mode = 1'b0;
    logic       step_in   = 1'b0;
    logic [1:0] sel;
    logic       sel_changed;
    logic [1:0] dbg_state;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    mux_select_sequencer #(
        .DIV_COUNT (DIV),
        .DEBOUNCE  (DB)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .auto_mode   (auto_mode),
        .step_in     (step_in),
        .sel         (sel),
        .sel_changed (sel_changed),
        .dbg_state   (dbg_state)
    );

    // ---------------- reference model ----------------
    // Button: level seen two edges late; a level different from the accepted
    // one must be seen DB times in a row to be accepted. Accepting "high"
    // makes a press that advances sel on the following edge.
    // Divider: count of consecutive edges with enable&auto_mode; every DIV-th
    // such edge advances sel.
    logic       m_s1, m_s2, m_acc, m_pend, m_fired, m_tick, m_adv, m_sample;
    int         m_run, m_auto_n, m_sel;
    logic       m_chg;
    logic [1:0] m_st;
    logic [4:0] exp_q[$];

    always @(posedge clock) begin
        if (reset) begin
            m_s1 = 0; m_s2 = 0; m_acc = 0; m_pend = 0;
            m_run = 0; m_auto_n = 0; m_sel = 0; m_chg = 0;
        end else begin
            m_auto_n = (enable && auto_mode) ? m_auto_n + 1 : 0;
            m_tick   = (m_auto_n != 0) && (m_auto_n % DIV == 0);
            m_adv    = enable && (auto_mode ? m_tick : m_pend);
            m_chg    = m_adv;
            if (m_adv) m_sel = (m_sel + 1) % 4;
            m_sample = m_s2;
            m_fired  = 0;
            if (m_sample != m_acc) begin
                m_run++;
                if (m_run == DB) begin
                    m_acc   = m_sample;
                    m_run   = 0;
                    m_fired = m_sample;
                end
            end else begin
                m_run = 0;
            end
            m_pend = m_fired;
            m_s2   = m_s1;
            m_s1   = step_in;
        end
        if (!m_acc) m_st = (m_run != 0) ? PRESS_CHK : IDLE;
        else        m_st = (m_run != 0) ? REL_CHK   : HELD;
        exp_q.push_back({2'(m_sel), m_chg, m_st});
    end

    // ---------------- scoreboard: per-cycle model compare ----------------
    logic [4:0] exp_v;
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            vectors++;
            if ({sel, sel_changed, dbg_state} !== exp_v) begin
                miscompares++;
                $display("FAIL model t=%0t: got sel=%0d chg=%0b st=%0d, need sel=%0d chg=%0b st=%0d",
                         $time, sel, sel_changed, dbg_state, exp_v[4:3], exp_v[2], exp_v[1:0]);
            end
        end
    end

    // ---------------- driver / checker tasks ----------------
    task automatic edges(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        edges(n);
        reset = 1'b0;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s t=%0t: got %0d, need %0d", name, $time, got, exp);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset held 2 cycles, then enable=0 with a toggling button.
        edges(2);
        reset = 1'b0;
        chk("reset_sel", sel, 0);
        chk("reset_chg", sel_changed, 0);
        for (int k = 0; k < 20; k++) begin
            step_in = 1'($urandom_range(0, 1));
            edges(1);
            chk("frozen_sel", sel, 0);
            chk("frozen_chg", sel_changed, 0);
        end

        // Auto stepping from edge 1: advances at 4, 8, 12, 16.
        step_in = 1'b0;
        do_reset(2);
        enable = 1'b1; auto_mode = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            edges(1);
            chk("auto_sel", sel, (k / 4) % 4);
            chk("auto_chg", sel_changed, (k % 4 == 0) ? 1 : 0);
        end

        // Manual: held 10 cycles from edge 1 -> single advance at edge 6.
        auto_mode = 1'b0;
        do_reset(2);
        step_in = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            edges(1);
            chk("man_sel", sel, (k >= 6) ? 1 : 0);
            chk("man_chg", sel_changed, (k == 6) ? 1 : 0);
            if (k == 10) step_in = 1'b0;
        end

        // Glitch rejection: high 2, low 5, high 2, low 10.
        do_reset(2);
        for (int k = 0; k < 19; k++) begin
            step_in = (k < 2) || (k >= 7 && k < 9);
            edges(1);
            chk("glitch_sel", sel, 0);
        end
        // Followed by a clean press.
        step_in = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            edges(1);
            chk("clean_sel", sel, (k >= 6) ? 1 : 0);
            if (k == 6) step_in = 1'b0;
        end

        // Reset in the middle of auto stepping.
        do_reset(2);
        auto_mode = 1'b1;
        edges(9);
        chk("pre_rst_sel", sel, 2);
        reset = 1'b1;
        edges(1);
        chk("mid_rst_sel", sel, 0);
        chk("mid_rst_chg", sel_changed, 0);
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            edges(1);
            chk("post_rst_sel", sel, (k == 4) ? 1 : 0);
        end

        // Auto off at edge 3, on again at edge 7: next advance at edge 10.
        do_reset(2);
        edges(2);
        auto_mode = 1'b0;
        edges(4);
        auto_mode = 1'b1;
        for (int k = 7; k <= 10; k++) begin
            edges(1);
            chk("resume_sel", sel, (k == 10) ? 1 : 0);
        end
        // Press during auto mode is ignored; only ticks at 14 and 18 advance.
        step_in = 1'b1;
        for (int k = 11; k <= 20; k++) begin
            edges(1);
            chk("auto_press_sel", sel, (k < 14) ? 1 : (k < 18) ? 2 : 3);
            if (k == 18) step_in = 1'b0;
        end

        // Random traffic, checked by the model only.
        do_reset(2);
        enable = 1'b1; auto_mode = 1'b0; step_in = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 49) == 0) enable    = ~enable;
            if ($urandom_range(0, 39) == 0) auto_mode = ~auto_mode;
            if ($urandom_range(0, 5)  == 0) step_in   = ~step_in;
            reset = ($urandom_range(0, 299) == 0);
            edges(1);
        end
        reset = 1'b0;
        edges(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
